mdl_mskdeser: RTL and testbench

Serial-to-parallel receive path for the bubble data loops: the counterpart of the mask-register serializer. Each bit slot carries one data bit from the loop array and the matching mask bit. The block keeps only data bits whose mask bit is 1 (good loops), assembles them LSB-first into 16-bit words (4-bit words in 4-bit mode), and hands each word to the data-buffer side through a valid/ack holding register. It sits between the bubble read-data input and the FIFO/DMA side, on the same 2 MHz bit-slot grid as the mask serializer.

---
 rtl/mdl_mskdeser.sv | 98 +++++++++
 tb/tb_mdl_mskdeser.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdl_mskdeser.sv
// Masked serial-to-parallel receiver for the bubble data loops: keeps data bits from good
// loops, packs them LSB-first into 16-bit (or 4-bit) words behind a valid/ack holding register.
module mdl_mskdeser (
  input  logic        i_MCLK,
  input  logic        i_RST,
  input  logic        i_CLK2M_PCEN_n,
  input  logic        i_RXEN,
  input  logic        i_4BEN_n,
  input  logic        i_MSK,
  input  logic        i_SDI,
  input  logic        i_FLUSH,
  input  logic        i_WORD_ACK,
  output logic [15:0] o_DOUT,
  output logic        o_WORD_VLD,
  output logic        o_OVF,
  output logic [7:0]  o_WCNT
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t      state_q, state_n;
  logic        rxen_q;
  logic        mode4_q, mode4_n;
  logic [15:0] asm_q, asm_n, asm_a, word;
  logic [4:0]  cnt_q, cnt_n, cnt_a;
  logic [15:0] dout_n;
  logic        vld_n, ovf_n;
  logic [7:0]  wcnt_n;
  logic        rise, active, accept, complete, flush_xfer, xfer, overrun;

  always_comb begin
    rise     = i_RXEN & ~rxen_q;
    active   = rise | ((state_q == ST_RUN) & i_RXEN);
    mode4_n  = rise ? ~i_4BEN_n : mode4_q;
    // A page start clears everything first so a coinciding slot lands in bit 0.
    asm_a    = rise ? 16'h0000 : asm_q;
    cnt_a    = rise ? 5'd0 : cnt_q;
    wcnt_n   = rise ? 8'd0 : o_WCNT;
    ovf_n    = rise ? 1'b0 : o_OVF;
    accept   = active & ~i_CLK2M_PCEN_n & i_MSK;
    if (accept) begin
      asm_a[cnt_a[3:0]] = i_SDI;
      cnt_a             = cnt_a + 5'd1;
    end
    complete   = accept & (cnt_a == (mode4_n ? 5'd4 : 5'd16));
    flush_xfer = active & i_FLUSH & ~complete & (cnt_a != 5'd0);
    xfer       = complete | flush_xfer;
    word       = mode4_n ? {12'h000, asm_a[3:0]} : asm_a;
    overrun    = xfer & o_WORD_VLD & ~i_WORD_ACK;

    dout_n  = o_DOUT;
    vld_n   = o_WORD_VLD & ~i_WORD_ACK;
    asm_n   = asm_a;
    cnt_n   = cnt_a;
    state_n = active ? ST_RUN : ST_IDLE;

    // An overrun drops the new word; otherwise the word loads even if ack frees the slot now.
    if (xfer) begin
      asm_n = 16'h0000;
      cnt_n = 5'd0;
      if (overrun) begin
        ovf_n = 1'b1;
      end else begin
        dout_n = word;
        vld_n  = 1'b1;
        wcnt_n = wcnt_n + 8'd1;
      end
    end else if (!active) begin
      asm_n = 16'h0000;
      cnt_n = 5'd0;
    end
  end

  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      state_q    <= ST_IDLE;
      rxen_q     <= 1'b0;
      mode4_q    <= 1'b0;
      asm_q      <= 16'h0000;
      cnt_q      <= 5'd0;
      o_DOUT     <= 16'h0000;
      o_WORD_VLD <= 1'b0;
      o_OVF      <= 1'b0;
      o_WCNT     <= 8'd0;
    end else begin
      state_q    <= state_n;
      rxen_q     <= i_RXEN;
      mode4_q    <= mode4_n;
      asm_q      <= asm_n;
      cnt_q      <= cnt_n;
      o_DOUT     <= dout_n;
      o_WORD_VLD <= vld_n;
      o_OVF      <= ovf_n;
      o_WCNT     <= wcnt_n;
    end
  end

endmodule

// File: tb/tb_mdl_mskdeser.sv
// Bench for mdl_mskdeser: directed scenarios plus a random run, all compared against a
// queue-based behavioural model of the accepted-bit stream.
module tb_mdl_mskdeser;

  logic        clk = 1'b0;
  logic        rst, pcen_n, rxen, ben_n, msk, sdi, flush, ack;
  logic        cur_ben;
  logic [15:0] o_dout;
  logic        o_vld, o_ovf;
  logic [7:0]  o_wcnt;
  int          n_checks = 0;
  int          n_pass = 0;

  logic        m_running, m_prev, m_mode4, m_vld, m_ovf;
  logic        m_bits[$];
  logic [15:0] m_dout;
  logic [7:0]  m_wcnt;

  always #5 clk = ~clk;

  mdl_mskdeser dut (
    .i_MCLK(clk), .i_RST(rst), .i_CLK2M_PCEN_n(pcen_n), .i_RXEN(rxen),
    .i_4BEN_n(ben_n), .i_MSK(msk), .i_SDI(sdi), .i_FLUSH(flush), .i_WORD_ACK(ack),
    .o_DOUT(o_dout), .o_WORD_VLD(o_vld), .o_OVF(o_ovf), .o_WCNT(o_wcnt)
  );

  task automatic model_deliver();
    logic [15:0] w;
    w = 16'h0000;
    foreach (m_bits[i]) w[i] = m_bits[i];
    if (m_vld && !ack) m_ovf = 1'b1;
    else begin
      m_dout = w;
      m_vld  = 1'b1;
      m_wcnt = m_wcnt + 8'd1;
    end
    m_bits.delete();
  endtask

  // Model of one MCLK edge in terms of the accepted-bit queue of the current page.
  task automatic model_edge();
    logic ack_ok, delivered;
    int   limit;
    if (rst) begin
      m_running = 0; m_mode4 = 0; m_vld = 0; m_ovf = 0;
      m_dout = 16'h0000; m_wcnt = 8'd0; m_bits.delete();
    end else begin
      ack_ok    = m_vld && ack;
      delivered = 0;
      if (rxen && !m_prev) begin
        m_bits.delete(); m_wcnt = 8'd0; m_ovf = 0; m_mode4 = !ben_n; m_running = 1;
      end else if (m_running && !rxen) begin
        m_running = 0; m_bits.delete();
      end
      if (m_running) begin
        limit = m_mode4 ? 4 : 16;
        if (!pcen_n && msk) begin
          m_bits.push_back(sdi);
          if (m_bits.size() == limit) begin model_deliver(); delivered = 1; end
        end
        if (flush && !delivered && m_bits.size() > 0) begin model_deliver(); delivered = 1; end
      end
      if (!delivered && ack_ok) m_vld = 0;
    end
    m_prev = rst ? 1'b0 : rxen;
  endtask

  task automatic drive(input logic r, input logic rx, input logic pc, input logic m,
                       input logic d, input logic fl, input logic ak);
    @(negedge clk);
    rst = r; rxen = rx; pcen_n = pc; msk = m; sdi = d; flush = fl; ack = ak; ben_n = cur_ben;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input logic m, input logic d, input logic ak);
    drive(1'b0, 1'b1, 1'b0, m, d, 1'b0, ak);
  endtask

  task automatic idle_ack();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic new_page(input logic bn);
    cur_ben = bn;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [15:0] w, input int n, input logic ak_last);
    for (int i = 0; i < n; i++) slot(1'b1, w[i], (i == n - 1) ? ak_last : 1'b0);
  endtask

  task automatic test_reset();
    cur_ben = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (o_dout !== 16'h0000) $display("[TB] FAIL reset_dout got %h exp 0000", o_dout); else n_pass++;
    n_checks++; if (o_vld !== 1'b0) $display("[TB] FAIL reset_vld got %b exp 0", o_vld); else n_pass++;
    n_checks++; if (o_ovf !== 1'b0) $display("[TB] FAIL reset_ovf got %b exp 0", o_ovf); else n_pass++;
    n_checks++; if (o_wcnt !== 8'd0) $display("[TB] FAIL reset_wcnt got %0d exp 0", o_wcnt); else n_pass++;
  endtask

  task automatic test_16bit();
    logic [15:0] w;
    w = 16'hA5C3;
    new_page(1'b1);
    send_word(w, 15, 1'b0);
    n_checks++; if (o_vld !== 1'b0) $display("[TB] FAIL w16_early_vld got %b exp 0", o_vld); else n_pass++;
    slot(1'b1, w[15], 1'b0);
    n_checks++; if (o_dout !== 16'hA5C3) $display("[TB] FAIL w16_dout got %h exp a5c3", o_dout); else n_pass++;
    n_checks++; if (o_vld !== 1'b1) $display("[TB] FAIL w16_vld got %b exp 1", o_vld); else n_pass++;
    n_checks++; if (o_wcnt !== 8'd1) $display("[TB] FAIL w16_wcnt got %0d exp 1", o_wcnt); else n_pass++;
    idle_ack();
    n_checks++; if (o_vld !== 1'b0) $display("[TB] FAIL w16_ack got %b exp 0", o_vld); else n_pass++;
  endtask

  task automatic test_mask();
    new_page(1'b1);
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 0) slot(1'b1, 1'((i / 2) % 2), 1'b0);
      else slot(1'b0, 1'b1, 1'b0);
    end
    n_checks++; if (o_dout !== 16'hAAAA) $display("[TB] FAIL mask_dout got %h exp aaaa", o_dout); else n_pass++;
    n_checks++; if (o_wcnt !== 8'd1) $display("[TB] FAIL mask_wcnt got %0d exp 1", o_wcnt); else n_pass++;
    n_checks++; if (o_ovf !== 1'b0) $display("[TB] FAIL mask_ovf got %b exp 0", o_ovf); else n_pass++;
    idle_ack();
  endtask

  task automatic test_4bit();
    logic [3:0] r;
    new_page(1'b0);
    slot(1'b1, 1'b1, 1'b0); slot(1'b1, 1'b1, 1'b0); slot(1'b1, 1'b0, 1'b0); slot(1'b1, 1'b1, 1'b0);
    n_checks++; if (o_dout !== 16'h000B) $display("[TB] FAIL b4_dout got %h exp 000b", o_dout); else n_pass++;
    n_checks++; if (o_vld !== 1'b1) $display("[TB] FAIL b4_vld got %b exp 1", o_vld); else n_pass++;
    idle_ack();
    r = 4'($urandom);
    send_word({12'h000, r}, 4, 1'b0);
    n_checks++; if (o_dout !== {12'h000, r}) $display("[TB] FAIL b4_second got %h exp %h", o_dout, {12'h000, r}); else n_pass++;
    n_checks++; if (o_wcnt !== 8'd2) $display("[TB] FAIL b4_wcnt got %0d exp 2", o_wcnt); else n_pass++;
    idle_ack();
  endtask

  task automatic test_flush();
    new_page(1'b1);
    send_word(16'hFFFF, 5, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (o_dout !== 16'h001F) $display("[TB] FAIL flush_dout got %h exp 001f", o_dout); else n_pass++;
    n_checks++; if (o_vld !== 1'b1) $display("[TB] FAIL flush_vld got %b exp 1", o_vld); else n_pass++;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++; if ({o_dout, o_vld, o_ovf, o_wcnt} !== {16'h001F, 1'b1, 1'b0, 8'd1})
      $display("[TB] FAIL flush_empty got %h/%b/%b/%0d exp 001f/1/0/1", o_dout, o_vld, o_ovf, o_wcnt); else n_pass++;
    idle_ack();
  endtask

  task automatic test_overrun();
    logic [15:0] w1, w2;
    w1 = 16'($urandom); w2 = 16'($urandom);
    new_page(1'b1);
    send_word(w1, 16, 1'b0);
    send_word(w2, 16, 1'b0);
    n_checks++; if (o_ovf !== 1'b1) $display("[TB] FAIL ovr_flag got %b exp 1", o_ovf); else n_pass++;
    n_checks++; if (o_dout !== w1) $display("[TB] FAIL ovr_dout got %h exp %h", o_dout, w1); else n_pass++;
    n_checks++; if (o_wcnt !== 8'd1) $display("[TB] FAIL ovr_wcnt got %0d exp 1", o_wcnt); else n_pass++;
    idle_ack();
    new_page(1'b1);
    send_word(w1, 16, 1'b0);
    send_word(w2, 16, 1'b1);
    n_checks++; if ({o_dout, o_vld, o_ovf, o_wcnt} !== {w2, 1'b1, 1'b0, 8'd2})
      $display("[TB] FAIL ack_same_edge got %h/%b/%b/%0d exp %h/1/0/2", o_dout, o_vld, o_ovf, o_wcnt, w2); else n_pass++;
    idle_ack();
  endtask

  task automatic test_reset_mid();
    logic [15:0] w;
    w = 16'($urandom);
    new_page(1'b1);
    send_word(w, 16, 1'b0);
    send_word(16'h7F, 7, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++; if ({o_dout, o_vld, o_ovf, o_wcnt} !== 26'd0)
      $display("[TB] FAIL reset_mid got %h/%b/%b/%0d exp 0000/0/0/0", o_dout, o_vld, o_ovf, o_wcnt); else n_pass++;
    new_page(1'b1);
    send_word(w, 16, 1'b0);
    send_word(~w, 16, 1'b0);
    send_word(16'h1F, 5, 1'b0);
    new_page(1'b1);
    n_checks++; if ({o_ovf, o_wcnt} !== {1'b0, 8'd0}) $display("[TB] FAIL rerise_clear got %b/%0d exp 0/0", o_ovf, o_wcnt); else n_pass++;
    idle_ack();
    send_word(w ^ 16'h5A5A, 16, 1'b0);
    n_checks++; if (o_dout !== (w ^ 16'h5A5A)) $display("[TB] FAIL partial_drop got %h exp %h", o_dout, w ^ 16'h5A5A); else n_pass++;
    idle_ack();
  endtask

  task automatic test_rise_slot();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    send_word(16'h0000, 15, 1'b0);
    n_checks++; if (o_dout !== 16'h0001) $display("[TB] FAIL rise_slot got %h exp 0001", o_dout); else n_pass++;
    idle_ack();
  endtask

  task automatic test_random();
    logic rx, pc, m, d, fl, ak;
    new_page(1'($urandom));
    for (int i = 0; i < 600; i++) begin
      rx = ($urandom_range(0, 63) != 0);
      pc = 1'($urandom);
      m  = ($urandom_range(0, 3) != 0);
      d  = 1'($urandom);
      fl = ($urandom_range(0, 15) == 0);
      ak = ($urandom_range(0, 2) == 0);
      if (!rx) cur_ben = 1'($urandom);
      drive(1'b0, rx, pc, m, d, fl, ak);
      n_checks++;
      if ({o_dout, o_vld, o_ovf, o_wcnt} !== {m_dout, m_vld, m_ovf, m_wcnt})
        $display("[TB] FAIL random_%0d got %h/%b/%b/%0d exp %h/%b/%b/%0d", i,
                 o_dout, o_vld, o_ovf, o_wcnt, m_dout, m_vld, m_ovf, m_wcnt);
      else n_pass++;
    end
  endtask

  initial begin
    m_prev = 1'b0;
    test_reset();
    test_16bit();
    test_mask();
    test_4bit();
    test_flush();
    test_overrun();
    test_reset_mid();
    test_rise_slot();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
